// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - length-prefixed byte-stream loader for the instruction memory
//
// Purpose: receives a count byte N followed by 4*N big-endian data bytes over a
// valid/ready handshake. Each group of four bytes becomes one 32-bit write at
// consecutive word addresses. The core is held in reset while a load runs.
//
// Optional feature: define IMEM_LOADER_CHKSUM_EN to require one trailing byte.
// That byte must equal the XOR of all data bytes, or the load ends in error.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   start        one-cycle pulse; begins a load from IDLE, DONE or ERR
//   in_data      stream byte
//   in_valid     in_data is valid
//   in_ready     loader accepts a byte this cycle
//   wr_en        one-cycle instruction-memory write strobe
//   wr_addr      word index being written, zero-extended to ADDR_W
//   wr_data      assembled instruction word
//   cpu_hold     core reset request; mirrors busy
//   busy         load in progress
//   done         last load succeeded; sticky until next start
//   err          last load failed; sticky until next start
//   words_loaded words written in the current or last load
module imem_loader #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [6:0]        words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_DATA  = 3'd2,
`ifdef IMEM_LOADER_CHKSUM_EN
    S_CHK   = 3'd3,
`endif
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic [6:0]        words_q, words_d;
  logic [6:0]        idx_q, idx_d;    // word index of the word being assembled
  logic [6:0]        cnt_q, cnt_d;    // latched word count N
  logic [1:0]        bcnt_q, bcnt_d;  // byte position within the current word
  logic [23:0]       asm_q, asm_d;    // first three bytes of the current word
`ifdef IMEM_LOADER_CHKSUM_EN
  logic [7:0]        chk_q, chk_d;
`endif

  logic accept;
  logic bad_count;

  // in_ready is a flop, so the handshake never depends combinationally on inputs.
  assign accept    = in_valid && in_ready_q;
  assign bad_count = (in_data == 8'd0) || ({24'd0, in_data} > DEPTH);

  always_comb begin
    state_d    = state_q;
    in_ready_d = in_ready_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    words_d    = words_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    bcnt_d     = bcnt_q;
    asm_d      = asm_q;
`ifdef IMEM_LOADER_CHKSUM_EN
    chk_d      = chk_q;
`endif

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_COUNT;
          in_ready_d = 1'b1;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          err_d      = 1'b0;
          words_d    = 7'd0;
          idx_d      = 7'd0;
          bcnt_d     = 2'd0;
`ifdef IMEM_LOADER_CHKSUM_EN
          chk_d      = 8'd0;
`endif
        end
      end

      S_COUNT: begin
        if (accept) begin
          if (bad_count) begin
            state_d    = S_ERR;
            err_d      = 1'b1;
            busy_d     = 1'b0;
            in_ready_d = 1'b0;
          end else begin
            // bad_count rules out N > DEPTH, so the low 7 bits hold all of N.
            cnt_d   = in_data[6:0];
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (accept) begin
`ifdef IMEM_LOADER_CHKSUM_EN
          chk_d = chk_q ^ in_data;
`endif
          asm_d  = {asm_q[15:0], in_data};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ADDR_W'(idx_q);
            wr_data_d = {asm_q, in_data};
            idx_d     = idx_q + 7'd1;
            words_d   = words_q + 7'd1;
            if (idx_q + 7'd1 == cnt_q) begin
`ifdef IMEM_LOADER_CHKSUM_EN
              state_d    = S_CHK;
`else
              state_d    = S_DONE;
              done_d     = 1'b1;
              busy_d     = 1'b0;
              in_ready_d = 1'b0;
`endif
            end
          end
        end
      end

`ifdef IMEM_LOADER_CHKSUM_EN
      S_CHK: begin
        if (accept) begin
          busy_d     = 1'b0;
          in_ready_d = 1'b0;
          if (in_data == chk_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
`endif

      default: begin
        state_d    = S_IDLE;
        in_ready_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 32'd0;
      words_q    <= 7'd0;
      idx_q      <= 7'd0;
      cnt_q      <= 7'd0;
      bcnt_q     <= 2'd0;
      asm_q      <= 24'd0;
`ifdef IMEM_LOADER_CHKSUM_EN
      chk_q      <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      words_q    <= words_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      bcnt_q     <= bcnt_d;
      asm_q      <= asm_d;
`ifdef IMEM_LOADER_CHKSUM_EN
      chk_q      <= chk_d;
`endif
    end
  end

  assign in_ready     = in_ready_q;
  assign busy         = busy_q;
  assign cpu_hold     = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;
  logic [6:0]  words_loaded;

  int nvec = 0;
  int nerr = 0;

  imem_loader #(.DEPTH(64), .ADDR_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".in_ready"}, in_ready, 0);
    chk({tag, ".wr_en"}, wr_en, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".cpu_hold"}, cpu_hold, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".err"}, err, 0);
    chk({tag, ".wr_addr"}, wr_addr, 0);
    chk({tag, ".wr_data"}, wr_data, 0);
    chk({tag, ".words"}, words_loaded, 0);
  endtask

  // Called right after the last data byte; sends the checksum byte when enabled.
  task automatic finish_ok(input string tag, input logic [7:0] xsum);
`ifdef IMEM_LOADER_CHKSUM_EN
    chk({tag, ".busy_before_chk"}, busy, 1);
    chk({tag, ".done_before_chk"}, done, 0);
    put(xsum);
    in_valid = 1'b0;
`else
    chk({tag, ".xsum_unused"}, {24'd0, xsum}, {24'd0, xsum});
    nvec--;
`endif
    chk({tag, ".done"}, done, 1);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".cpu_hold"}, cpu_hold, 0);
    chk({tag, ".in_ready"}, in_ready, 0);
  endtask

  logic [7:0]  prog [12];
  logic [31:0] words [3];

  initial begin
    prog = '{8'h24, 8'h08, 8'h00, 8'h05, 8'h24, 8'h09, 8'h00, 8'h07,
             8'h01, 8'h09, 8'h50, 8'h20};
    words = '{32'h24080005, 32'h24090007, 32'h01095020};

    rst = 1'b0; start = 1'b0; in_data = 8'h00; in_valid = 1'b0;
    tick(); tick();
    check_reset_values("reset");
    rst = 1'b1;
    tick();

    // Full load, streamed one byte per cycle.
    pulse_start();
    chk("full.busy_after_start", busy, 1);
    chk("full.ready_after_start", in_ready, 1);
    chk("full.hold_after_start", cpu_hold, 1);
    put(8'h03);
    chk("full.wr_en_after_n", wr_en, 0);
    for (int i = 0; i < 12; i++) begin
      put(prog[i]);
      if (i % 4 == 3) begin
        chk($sformatf("full.wr_en_w%0d", i / 4), wr_en, 1);
        chk($sformatf("full.wr_addr_w%0d", i / 4), wr_addr, i / 4);
        chk($sformatf("full.wr_data_w%0d", i / 4), wr_data, words[i / 4]);
        chk($sformatf("full.words_w%0d", i / 4), words_loaded, i / 4 + 1);
      end else if (i % 4 == 0 && i > 0) begin
        chk($sformatf("full.strobe_drop_w%0d", i / 4), wr_en, 0);
        chk($sformatf("full.data_hold_w%0d", i / 4), wr_data, words[i / 4 - 1]);
      end
    end
`ifdef IMEM_LOADER_CHKSUM_EN
    in_valid = 1'b0;
`endif
    finish_ok("full", 8'h7B);
    idle(1);
    chk("full.wr_en_clear", wr_en, 0);
    chk("full.addr_hold", wr_addr, 2);
    chk("full.data_hold", wr_data, 32'h01095020);
    chk("full.words_end", words_loaded, 3);
    chk("full.done_sticky", done, 1);

    // Bad count N=0.
    pulse_start();
    chk("bad0.done_cleared", done, 0);
    chk("bad0.words_cleared", words_loaded, 0);
    put(8'h00);
    in_valid = 1'b0;
    chk("bad0.err", err, 1);
    chk("bad0.busy", busy, 0);
    chk("bad0.in_ready", in_ready, 0);
    chk("bad0.wr_en", wr_en, 0);
    idle(2);
    chk("bad0.wr_en_later", wr_en, 0);
    chk("bad0.err_sticky", err, 1);

    // Bad count N=65.
    pulse_start();
    chk("bad65.err_cleared", err, 0);
    chk("bad65.busy_start", busy, 1);
    put(8'h41);
    in_valid = 1'b0;
    chk("bad65.err", err, 1);
    chk("bad65.busy", busy, 0);
    chk("bad65.wr_en", wr_en, 0);
    idle(1);
    chk("bad65.wr_en_later", wr_en, 0);

    // N=64 is the largest legal count; abort it with reset.
    pulse_start();
    put(8'h40);
    in_valid = 1'b0;
    chk("n64.err", err, 0);
    chk("n64.busy", busy, 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // Backpressure: gaps of 5 idle cycles, plus a start pulse mid-load.
    pulse_start();
    put(8'h01);
    idle(5);
    put(8'hDE);
    idle(2);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("bp.busy_after_start", busy, 1);
    chk("bp.ready_after_start", in_ready, 1);
    idle(2);
    put(8'hAD);
    idle(5);
    put(8'hBE);
    idle(5);
    chk("bp.no_write_yet", wr_en, 0);
    put(8'hEF);
    in_valid = 1'b0;
    chk("bp.wr_en", wr_en, 1);
    chk("bp.wr_addr", wr_addr, 0);
    chk("bp.wr_data", wr_data, 32'hDEADBEEF);
    chk("bp.words", words_loaded, 1);
    finish_ok("bp", 8'h22);

    // Reset mid-load after the first word was written.
    pulse_start();
    put(8'h02);
    put(8'h11); put(8'h22); put(8'h33); put(8'h44);
    in_valid = 1'b0;
    chk("rst.wr_en", wr_en, 1);
    chk("rst.wr_data", wr_data, 32'h11223344);
    chk("rst.wr_addr", wr_addr, 0);
    chk("rst.busy_mid", busy, 1);
    rst = 1'b0;
    tick();
    check_reset_values("rst_mid");
    rst = 1'b1;
    tick();
    check_reset_values("rst_after");

`ifdef IMEM_LOADER_CHKSUM_EN
    pulse_start();
    put(8'h01);
    put(8'h01); put(8'h02); put(8'h04); put(8'h08);
    in_valid = 1'b0;
    chk("ck_ok.wr_data", wr_data, 32'h01020408);
    put(8'h0F);
    in_valid = 1'b0;
    chk("ck_ok.done", done, 1);
    chk("ck_ok.err", err, 0);

    pulse_start();
    put(8'h01);
    put(8'h01); put(8'h02); put(8'h04); put(8'h08);
    in_valid = 1'b0;
    chk("ck_bad.wr_en", wr_en, 1);
    chk("ck_bad.wr_data", wr_data, 32'h01020408);
    put(8'h0E);
    in_valid = 1'b0;
    chk("ck_bad.err", err, 1);
    chk("ck_bad.done", done, 0);
    chk("ck_bad.busy", busy, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream loader that writes program words into the instruction memory before the single-cycle core runs. It accepts a length-prefixed, big-endian byte stream over a valid/ready handshake and assembles 32-bit words. It issues one write per word at consecutive word addresses. It holds the core in reset until the program is loaded.

## Interface
- DEPTH, 64: instruction memory depth in words; maximum accepted word count.
- ADDR_W, 32: width of `wr_addr`, matching the fetch-side word address.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- in_data  in  8  stream byte.
- in_valid  in  1  `in_data` is valid.
- in_ready  out  1  loader can accept a byte; a byte transfers when `in_valid && in_ready`.
- wr_en  out  1  one-cycle instruction-memory write strobe.
- wr_addr  out  ADDR_W  word index being written, zero-extended.
- wr_data  out  32  assembled instruction word.
- cpu_hold  out  1  keeps the core in reset; equals `busy`.
- busy  out  1  a load is in progress.
- done  out  1  the last load completed successfully; sticky until the next `start`.
- err  out  1  the last load failed; sticky until the next `start`.
- words_loaded  out  7  number of words written in the current or last load.

## Operation
- **States:** IDLE, COUNT, DATA, CHK (only when configured), DONE, ERR.
- **IDLE/DONE/ERR + `start`:**
  - Go to COUNT.
  - Clear `done`, `err`, `words_loaded`, the byte counter, the word address and the checksum.
  - Set `busy`.
- **COUNT:**
  - Accept one byte N.
  - If N == 0 or N > DEPTH, go to ERR.
  - Otherwise latch N and go to DATA.
- **DATA:**
  - Accept bytes MSB first: byte 0 goes to [31:24] and byte 3 goes to [7:0].
  - On the 4th byte, the next cycle drives `wr_en`=1 with `wr_data` = the assembled word and `wr_addr` = the current word index.
  - On that 4th byte the word index increments, `words_loaded` increments and the byte counter wraps to 0.
  - After word N-1 is written, go to CHK or DONE.
- **Checksum:** a running XOR of all data bytes is maintained in DATA; it is used only in CHK.
- **`in_ready`:**
  - 1 in COUNT, DATA and CHK.
  - 0 in IDLE, DONE and ERR.
  - Bytes presented while `in_ready`=0 are not consumed.
- **`start` while `busy`:** ignored.
- **`in_valid` low mid-word:** the partial word is retained indefinitely; there is no timeout.
- **ERR:**
  - `busy`=0 and `err`=1.
  - No further writes.
  - Words already written stay in memory.
- **Reset mid-load:** returns to IDLE immediately; outputs take their reset values. A partially written memory is not cleared.

## Timing
- **Reset values:**
  - `in_ready`, `wr_en`, `busy`, `cpu_hold`, `done`, `err` = 0.
  - `wr_addr`, `wr_data` = 0.
  - `words_loaded` = 0.
  - State = IDLE.
- **`start` response:** `start` sampled at edge t gives `busy`=1 and `in_ready`=1 from t+1.
- **Write latency:** 4th byte of a word accepted at edge t gives `wr_en`=1 during the cycle after t, for exactly one cycle.
  - `wr_addr` and `wr_data` hold their values until the next write.
- **Back-to-back bytes:** a byte may be accepted in the same cycle `wr_en` is high. Sustained throughput is one byte per cycle, i.e. one write per 4 cycles.
- **Completion without checksum:** last data byte accepted at edge t gives, at t+1, `wr_en`=1, `done`=1, `busy`=0 and `in_ready`=0.
- **COUNT error:** an invalid N accepted at edge t gives `err`=1 and `busy`=0 at t+1.
- **Outputs:** all outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- **Macro `IMEM_LOADER_CHKSUM_EN` defined:**
  - After the last data byte, go to CHK.
  - Accept one byte. If it equals the XOR of all 4N data bytes, go to DONE; otherwise go to ERR.
  - The result is visible the cycle after the checksum byte is accepted.
  - The last word is still written before the check.
- **Macro undefined:**
  - No CHK state and no checksum register.
  - DATA goes directly to DONE.

## Test plan
- **Reset mid-load:**
  - Sequence: `start`, N=0x02, bytes 11 22 33 44, then drop `rst` for 1 cycle.
  - Response: write of 0x11223344 at address 0, then all outputs return to reset values; `words_loaded`=0.
- **Full load:**
  - Sequence: `start`, N=0x03, bytes 24 08 00 05 | 24 09 00 07 | 01 09 50 20 streamed continuously.
  - Response: three writes, 0x24080005@0, 0x24090007@1 and 0x01095020@2, each one cycle after its 4th byte.
  - End state: `done`=1, `busy`=0, `words_loaded`=3.
- **Bad count:**
  - Sequence: `start`, N=0x00; then a second run with `start`, N=0x41 (65 > DEPTH).
  - Response: `err`=1 on the next cycle, no `wr_en` ever.
- **Backpressure and stalls:**
  - Sequence: N=1, bytes DE AD BE EF with `in_valid` low for 5 cycles between each byte, plus a `start` pulse mid-load.
  - Response: a single write of 0xDEADBEEF@0; the `start` pulse is ignored.
- **Checksum (macro defined):**
  - Sequence: N=1, bytes 01 02 04 08, checksum 0x0F.
  - Response: `done`=1.
  - Repeat with checksum 0x0E: the word is still written, then `err`=1.
